// File: rtl/ex_stage.sv
// Execute stage: latches the decode-to-execute bus under the stall vector, computes the ALU
// result, issues the data-SRAM request and drives forwarding/load-use signals back to decode.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 164,
  parameter int EX_TO_MEM_WD = 81,
  parameter int StallBus     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    ex_we,
  output logic [4:0]              ex_waddr,
  output logic [31:0]             ex_wdata,
  output logic                    ex_ram_read,
  output logic                    stallreq
);

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  logic [ID_TO_EX_WD-1:0] id_to_ex_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_to_ex_r <= '0;
    end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
      id_to_ex_r <= '0;
    end else if (stall[2] == NO_STOP) begin
      id_to_ex_r <= id_to_ex_bus;
    end
  end

  logic [4:0]  mem_op;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        sel_rf_res;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  assign {mem_op, pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
          rf_we, rf_waddr, sel_rf_res, rs_data, rt_data} = id_to_ex_r;

  logic [31:0] src1;
  logic [31:0] src2;

  // Select vectors are one-hot; an all-zero vector yields a zero operand.
  assign src1 = ({32{sel_src1[0]}} & rs_data)
              | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});

  assign src2 = ({32{sel_src2[0]}} & rt_data)
              | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({32{sel_src2[2]}} & 32'd8)
              | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});

  logic        op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
  logic        op_or, op_xor, op_sll, op_srl, op_sra, op_lui;
  logic [31:0] ex_result;

  assign {op_add, op_sub, op_slt, op_sltu, op_and, op_nor,
          op_or, op_xor, op_sll, op_srl, op_sra, op_lui} = alu_op;

  always_comb begin
    ex_result = 32'b0;
    if (op_add)  ex_result = ex_result | (src1 + src2);
    if (op_sub)  ex_result = ex_result | (src1 - src2);
    if (op_slt)  ex_result = ex_result | {31'b0, $signed(src1) < $signed(src2)};
    if (op_sltu) ex_result = ex_result | {31'b0, src1 < src2};
    if (op_and)  ex_result = ex_result | (src1 & src2);
    if (op_nor)  ex_result = ex_result | ~(src1 | src2);
    if (op_or)   ex_result = ex_result | (src1 | src2);
    if (op_xor)  ex_result = ex_result | (src1 ^ src2);
    if (op_sll)  ex_result = ex_result | (src2 << src1[4:0]);
    if (op_srl)  ex_result = ex_result | (src2 >> src1[4:0]);
    if (op_sra)  ex_result = ex_result | 32'($signed(src2) >>> src1[4:0]);
    if (op_lui)  ex_result = ex_result | {src2[15:0], 16'b0};
  end

  logic [3:0]  byte_wen;
  logic [31:0] store_data;

  // Misaligned addresses are not trapped; sh simply ignores addr[0].
  always_comb begin
    byte_wen   = 4'b0000;
    store_data = rt_data;
    if (ram_wen[0]) begin
      byte_wen   = 4'b1111;
      store_data = rt_data;
    end else if (ram_wen[1]) begin
      byte_wen   = ex_result[1] ? 4'b1100 : 4'b0011;
      store_data = {2{rt_data[15:0]}};
    end else if (ram_wen[2]) begin
      byte_wen   = 4'b0001 << ex_result[1:0];
      store_data = {4{rt_data[7:0]}};
    end
  end

  assign data_sram_en    = ram_en;
  assign data_sram_wen   = byte_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = store_data;

  assign ex_we       = rf_we;
  assign ex_waddr    = rf_waddr;
  assign ex_wdata    = ex_result;
  assign ex_ram_read = ram_en & sel_rf_res;
  assign stallreq    = 1'b0;

  assign ex_to_mem_bus = {mem_op, pc, ram_en, byte_wen, sel_rf_res, rf_we, rf_waddr, ex_result};

  logic unused_bits;
  assign unused_bits = &{1'b0, inst[31:16], ram_wen[3], stall[StallBus-1:4], stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected results are queued when a bus is driven and
// compared one cycle later when the stage presents them.
module tb_ex_stage;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [163:0] id_to_ex_bus;
  logic [80:0]  ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         ex_we;
  logic [4:0]   ex_waddr;
  logic [31:0]  ex_wdata;
  logic         ex_ram_read;
  logic         stallreq;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
    .ex_to_mem_bus(ex_to_mem_bus), .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .ex_we(ex_we), .ex_waddr(ex_waddr),
    .ex_wdata(ex_wdata), .ex_ram_read(ex_ram_read), .stallreq(stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  mo;
    logic [31:0] pc;
    logic        re;
    logic [3:0]  wen;
    logic        sel;
    logic        we;
    logic [4:0]  wa;
    logic        chk_wd;
    logic [31:0] wd;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    pass_cnt = 0;
  int    fail_cnt = 0;
  int    total_cnt = 0;

  localparam logic [11:0] ADD = 12'h800, SUB = 12'h400, SLT = 12'h200, SLTU = 12'h100;
  localparam logic [11:0] AND = 12'h080, NOR = 12'h040, OR = 12'h020, XOR = 12'h010;
  localparam logic [11:0] SLL = 12'h008, SRL = 12'h004, SRA = 12'h002, LUI = 12'h001;
  localparam logic [2:0]  S1_RS = 3'b001, S1_PC = 3'b010, S1_SA = 3'b100;
  localparam logic [3:0]  S2_RT = 4'b0001, S2_IMMS = 4'b0010, S2_C8 = 4'b0100, S2_IMMZ = 4'b1000;
  localparam logic [3:0]  W_SW = 4'b0001, W_SH = 4'b0010, W_SB = 4'b0100;
  localparam logic [5:0]  GO = 6'b000000, BUBBLE = 6'b000111, HOLD = 6'b001111;

  function automatic logic [163:0] mk(
    input logic [4:0] mo, input logic [31:0] pc, input logic [31:0] inst,
    input logic [11:0] alu, input logic [2:0] s1, input logic [3:0] s2,
    input logic re, input logic [3:0] rw, input logic we, input logic [4:0] wa,
    input logic sel, input logic [31:0] rs, input logic [31:0] rt);
    return {mo, pc, inst, alu, s1, s2, re, rw, we, wa, sel, rs, rt};
  endfunction

  function automatic exp_t ex(
    input logic [31:0] res, input logic [4:0] mo, input logic [31:0] pc, input logic re,
    input logic [3:0] wen, input logic sel, input logic we, input logic [4:0] wa,
    input logic chk_wd, input logic [31:0] wd);
    exp_t e;
    e = '{res: res, mo: mo, pc: pc, re: re, wen: wen, sel: sel, we: we, wa: wa,
          chk_wd: chk_wd, wd: wd};
    return e;
  endfunction

  task automatic chk(input string tag, input string name, input logic [80:0] obs,
                     input logic [80:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, name, obs, expv);
    end
  endtask

  task automatic check();
    exp_t  e;
    string t;
    if (exp_q.size() == 0 || tag_q.size() == 0) begin
      total_cnt++;
      fail_cnt++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, "bus", ex_to_mem_bus, {e.mo, e.pc, e.re, e.wen, e.sel, e.we, e.wa, e.res});
    chk(t, "en", 81'(data_sram_en), 81'(e.re));
    chk(t, "wen", 81'(data_sram_wen), 81'(e.wen));
    chk(t, "addr", 81'(data_sram_addr), 81'(e.res));
    if (e.chk_wd) chk(t, "wdata", 81'(data_sram_wdata), 81'(e.wd));
    chk(t, "ex_we", 81'(ex_we), 81'(e.we));
    chk(t, "ex_waddr", 81'(ex_waddr), 81'(e.wa));
    chk(t, "ex_wdata", 81'(ex_wdata), 81'(e.res));
    chk(t, "ram_read", 81'(ex_ram_read), 81'(e.re & e.sel));
    chk(t, "stallreq", 81'(stallreq), 81'(0));
  endtask

  task automatic run(input string tag, input logic [163:0] b, input logic [5:0] s,
                     input exp_t e);
    id_to_ex_bus = b;
    stall = s;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check();
  endtask

  exp_t zero_e, lw_e;
  logic [163:0] junk;

  initial begin
    zero_e = ex(32'h0, 5'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'h0, 1'b1, 32'h0);
    junk = mk(5'h1f, 32'hDEADBEEF, 32'h12345678, ADD, S1_RS, S2_RT, 1'b1, W_SW, 1'b1,
              5'd7, 1'b1, 32'h11111111, 32'h22222222);
    rst = 1'b1;
    stall = GO;
    id_to_ex_bus = junk;
    run("reset", junk, GO, zero_e);
    rst = 1'b0;

    run("add_ovf", mk(5'h0, 32'hBFC00000, 32'h0, ADD, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd9,
        1'b0, 32'h7FFFFFFF, 32'h1), GO,
        ex(32'h80000000, 5'h0, 32'hBFC00000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 1'b0, 32'h0));
    run("sll", mk(5'h0, 32'hBFC00004, 32'h00000100, SLL, S1_SA, S2_RT, 1'b0, 4'h0, 1'b1, 5'd2,
        1'b0, 32'h0, 32'h0000000F), GO,
        ex(32'h000000F0, 5'h0, 32'hBFC00004, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 1'b0, 32'h0));
    run("lui", mk(5'h0, 32'hBFC00008, 32'h3C011234, LUI, 3'b000, S2_IMMZ, 1'b0, 4'h0, 1'b1,
        5'd1, 1'b0, 32'hFFFFFFFF, 32'h0), GO,
        ex(32'h12340000, 5'h0, 32'hBFC00008, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1, 1'b0, 32'h0));
    run("sra", mk(5'h0, 32'hBFC0000C, 32'h000007C0, SRA, S1_SA, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3,
        1'b0, 32'h0, 32'h80000000), GO,
        ex(32'hFFFFFFFF, 5'h0, 32'hBFC0000C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 1'b0, 32'h0));
    run("srl", mk(5'h0, 32'hBFC0000C, 32'h000007C0, SRL, S1_SA, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3,
        1'b0, 32'h0, 32'h80000000), GO,
        ex(32'h00000001, 5'h0, 32'hBFC0000C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 1'b0, 32'h0));
    run("jal", mk(5'h0, 32'hBFC00010, 32'h0C000000, ADD, S1_PC, S2_C8, 1'b0, 4'h0, 1'b1,
        5'd31, 1'b0, 32'h0, 32'h0), GO,
        ex(32'hBFC00018, 5'h0, 32'hBFC00010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd31, 1'b0, 32'h0));
    run("sub", mk(5'h0, 32'h0, 32'h0, SUB, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0,
        32'd3, 32'd5), GO,
        ex(32'hFFFFFFFE, 5'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 1'b0, 32'h0));
    run("slt", mk(5'h0, 32'h0, 32'h0, SLT, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0,
        32'hFFFFFFFF, 32'd1), GO,
        ex(32'h1, 5'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 1'b0, 32'h0));
    run("sltu", mk(5'h0, 32'h0, 32'h0, SLTU, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0,
        32'hFFFFFFFF, 32'd1), GO,
        ex(32'h0, 5'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 1'b0, 32'h0));
    run("nor", mk(5'h0, 32'h0, 32'h0, NOR, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0,
        32'hF0F0F0F0, 32'h0F0F0000), GO,
        ex(32'h00000F0F, 5'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 1'b0, 32'h0));
    run("xor", mk(5'h0, 32'h0, 32'h0, XOR, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0,
        32'hFFFF0000, 32'h0F0F0F0F), GO,
        ex(32'hF0F00F0F, 5'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 1'b0, 32'h0));
    run("andi", mk(5'h0, 32'h0, 32'h3001FF00, AND, S1_RS, S2_IMMZ, 1'b0, 4'h0, 1'b1, 5'd6,
        1'b0, 32'h12345678, 32'h0), GO,
        ex(32'h00005600, 5'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd6, 1'b0, 32'h0));
    run("ori", mk(5'h0, 32'h0, 32'h34018001, OR, S1_RS, S2_IMMZ, 1'b0, 4'h0, 1'b1, 5'd6,
        1'b0, 32'h0, 32'h0), GO,
        ex(32'h00008001, 5'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd6, 1'b0, 32'h0));
    run("no_op", mk(5'h0, 32'h0, 32'h0, 12'h000, S1_RS, S2_RT, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
        32'h5, 32'h6), GO,
        ex(32'h0, 5'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0));

    run("sb_3", mk(5'h0, 32'hBFC00020, 32'hA0000003, ADD, S1_RS, S2_IMMS, 1'b1, W_SB, 1'b0,
        5'd0, 1'b0, 32'h1000, 32'hAABBCCDD), GO,
        ex(32'h1003, 5'h0, 32'hBFC00020, 1'b1, 4'b1000, 1'b0, 1'b0, 5'd0, 1'b1, 32'hDDDDDDDD));
    run("sb_0", mk(5'h0, 32'hBFC00024, 32'hA0000000, ADD, S1_RS, S2_IMMS, 1'b1, W_SB, 1'b0,
        5'd0, 1'b0, 32'h1000, 32'h00000077), GO,
        ex(32'h1000, 5'h0, 32'hBFC00024, 1'b1, 4'b0001, 1'b0, 1'b0, 5'd0, 1'b1, 32'h77777777));
    run("sh_2", mk(5'h0, 32'hBFC00028, 32'hA4000002, ADD, S1_RS, S2_IMMS, 1'b1, W_SH, 1'b0,
        5'd0, 1'b0, 32'h1000, 32'hAABBCCDD), GO,
        ex(32'h1002, 5'h0, 32'hBFC00028, 1'b1, 4'b1100, 1'b0, 1'b0, 5'd0, 1'b1, 32'hCCDDCCDD));
    run("sh_1", mk(5'h0, 32'hBFC0002C, 32'hA4000001, ADD, S1_RS, S2_IMMS, 1'b1, W_SH, 1'b0,
        5'd0, 1'b0, 32'h1000, 32'h12345678), GO,
        ex(32'h1001, 5'h0, 32'hBFC0002C, 1'b1, 4'b0011, 1'b0, 1'b0, 5'd0, 1'b1, 32'h56785678));
    run("sw_neg", mk(5'h0, 32'hBFC00030, 32'hAC00FFFC, ADD, S1_RS, S2_IMMS, 1'b1, W_SW, 1'b0,
        5'd0, 1'b0, 32'h2000, 32'hCAFEF00D), GO,
        ex(32'h1FFC, 5'h0, 32'hBFC00030, 1'b1, 4'b1111, 1'b0, 1'b0, 5'd0, 1'b1, 32'hCAFEF00D));

    lw_e = ex(32'h104, 5'b00001, 32'hBFC00034, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd8, 1'b0, 32'h0);
    run("lw", mk(5'b00001, 32'hBFC00034, 32'h8C000004, ADD, S1_RS, S2_IMMS, 1'b1, 4'h0, 1'b1,
        5'd8, 1'b1, 32'h100, 32'h0), GO, lw_e);
    for (int i = 0; i < 3; i++) run("hold", junk, HOLD, lw_e);
    rst = 1'b1;
    run("rst_hold", junk, HOLD, zero_e);
    rst = 1'b0;

    run("pre_bub", mk(5'h0, 32'hBFC00040, 32'h0, ADD, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd10,
        1'b0, 32'd20, 32'd22), GO,
        ex(32'd42, 5'h0, 32'hBFC00040, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10, 1'b0, 32'h0));
    run("bubble", junk, BUBBLE, zero_e);
    run("bub_hold", junk, HOLD, zero_e);
    rst = 1'b1;
    run("rst_vs_go", junk, GO, zero_e);
    rst = 1'b0;
    run("resume", mk(5'h0, 32'hBFC00044, 32'h0, ADD, S1_PC, S2_C8, 1'b0, 4'h0, 1'b1, 5'd31,
        1'b0, 32'h0, 32'h0), GO,
        ex(32'hBFC0004C, 5'h0, 32'hBFC00044, 1'b0, 4'h0, 1'b0, 1'b1, 5'd31, 1'b0, 32'h0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
